// File: rtl/agu_config_queue.sv
// Descriptor FIFO feeding the AGU one job at a time; start pulse 2 cycles after a push into an idle, empty queue.
// cfg_ready drops only when the FIFO is full; a job completes on agu_done.
module agu_config_queue #(
  parameter int IDX_W  = 8,
  parameter int TRIP_W = 8,
  parameter int LIM_W  = 6,
  parameter int KSIZE  = 3,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [1:0]                 mode,
  input  logic [IDX_W-1:0]           idx_cnt,
  input  logic [TRIP_W-1:0]          trip_cnt,
  input  logic                       is_new,
  input  logic [3:0]                 pad_code,
  input  logic                       cut_y,
  input  logic                       agu_done,
  output logic [1:0]                 conf_mode,
  output logic [IDX_W-1:0]           conf_idx_cnt,
  output logic [TRIP_W-1:0]          conf_trip_cnt,
  output logic                       conf_is_new,
  output logic                       conf_pad_u,
  output logic                       conf_pad_l,
  output logic [LIM_W-1:0]           conf_lim_r,
  output logic [LIM_W-1:0]           conf_lim_d,
  output logic [LIM_W-1:0]           conf_row_cnt,
  output logic                       start_fc,
  output logic                       start_conv,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     cfg_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [1:0]        mode;
    logic [IDX_W-1:0]  idx_cnt;
    logic [TRIP_W-1:0] trip_cnt;
    logic              is_new;
    logic [3:0]        pad_code;
    logic              cut_y;
  } desc_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RUN} state_t;

  desc_t            mem_q [DEPTH];
  desc_t            in_desc;
  desc_t            head;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  state_t           state_q, state_d;
  logic             push, pop;

  logic [1:0]        conf_mode_q;
  logic [IDX_W-1:0]  conf_idx_cnt_q;
  logic [TRIP_W-1:0] conf_trip_cnt_q;
  logic              conf_is_new_q, conf_pad_u_q, conf_pad_l_q;
  logic [LIM_W-1:0]  conf_lim_r_q, conf_lim_d_q, conf_row_cnt_q;
  logic [LIM_W-1:0]  lim_r_d, lim_d_d, row_cnt_d;
  logic [LIM_W-1:0]  trip_l, half_l, odd_l, pu_l, pd_l, cut_l, k_l;
  logic              unused_pad3;

  assign in_desc = '{mode: mode, idx_cnt: idx_cnt, trip_cnt: trip_cnt,
                     is_new: is_new, pad_code: pad_code, cut_y: cut_y};
  assign head    = mem_q[rd_ptr_q];

  // Ready looks at occupancy only, so a same-cycle pop never frees a slot early.
  assign cfg_ready = (level_q != LVL_W'(DEPTH));
  assign push      = cfg_valid && cfg_ready;
  assign cfg_level = level_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_desc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Limit arithmetic is deliberately modulo 2^LIM_W.
  assign trip_l    = LIM_W'(head.trip_cnt);
  assign half_l    = LIM_W'(head.trip_cnt >> 1);
  assign odd_l     = LIM_W'(head.trip_cnt[0]);
  assign pu_l      = LIM_W'(head.pad_code[0]);
  assign pd_l      = LIM_W'(head.pad_code[1]);
  assign cut_l     = LIM_W'(head.cut_y);
  assign k_l       = LIM_W'(KSIZE);
  assign row_cnt_d = half_l + odd_l - LIM_W'(1);
  assign lim_d_d   = k_l - pu_l - pd_l - cut_l;
  assign lim_r_d   = trip_l + k_l - LIM_W'(2) - pu_l - pd_l;
  assign unused_pad3 = head.pad_code[3];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = RUN;
      RUN:     if (agu_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conf_mode_q     <= '0;
      conf_idx_cnt_q  <= '0;
      conf_trip_cnt_q <= '0;
      conf_is_new_q   <= 1'b1;
      conf_pad_u_q    <= 1'b0;
      conf_pad_l_q    <= 1'b0;
      conf_lim_r_q    <= '0;
      conf_lim_d_q    <= '0;
      conf_row_cnt_q  <= '0;
    end else if (pop) begin
      conf_mode_q     <= head.mode;
      conf_idx_cnt_q  <= head.idx_cnt;
      conf_trip_cnt_q <= head.trip_cnt;
      conf_is_new_q   <= head.is_new;
      conf_pad_u_q    <= head.pad_code[0];
      conf_pad_l_q    <= head.pad_code[2];
      conf_lim_r_q    <= lim_r_d;
      conf_lim_d_q    <= lim_d_d;
      conf_row_cnt_q  <= row_cnt_d;
    end
  end

  assign conf_mode     = conf_mode_q;
  assign conf_idx_cnt  = conf_idx_cnt_q;
  assign conf_trip_cnt = conf_trip_cnt_q;
  assign conf_is_new   = conf_is_new_q;
  assign conf_pad_u    = conf_pad_u_q;
  assign conf_pad_l    = conf_pad_l_q;
  assign conf_lim_r    = conf_lim_r_q;
  assign conf_lim_d    = conf_lim_d_q;
  assign conf_row_cnt  = conf_row_cnt_q;
  assign start_fc      = (state_q == ISSUE) &&  conf_mode_q[0];
  assign start_conv    = (state_q == ISSUE) && !conf_mode_q[0];
  assign busy          = (state_q != IDLE) || (level_q != '0);

endmodule

// File: doc/agu_config_queue.md
Name: agu_config_queue

Overview:
- Parametrised successor to the PE's single-shot AGU configuration latch.
- Accepts AGU job descriptors through a valid/ready handshake into a DEPTH-entry FIFO.
- Derives padding/limit fields for a generic KSIZE kernel and dispatches one job at a time to the AGU, waiting for agu_done before issuing the next job.
- Lets the controller queue the next tile's configuration while the current one runs, removing dead cycles between jobs.

Parameters:
- IDX_W, 8, width of idx_cnt
- TRIP_W, 8, width of trip_cnt
- LIM_W, 6, width of lim_r, lim_d and row_cnt
- KSIZE, 3, kernel height/width used in limit derivation (>=2)
- DEPTH, 2, descriptor FIFO depth (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cfg_valid  in  1  descriptor present
- cfg_ready  out  1  FIFO not full
- mode  in  2  job mode; 01/11 = fc, 00/10 = conv
- idx_cnt  in  IDX_W  number of indices
- trip_cnt  in  TRIP_W  cycles per trip
- is_new  in  1  new accumulation
- pad_code  in  4  {R,L,D,U}
- cut_y  in  1  drop last kernel row
- agu_done  in  1  AGU finished current job (1-cycle pulse)
- conf_mode  out  2  active mode
- conf_idx_cnt  out  IDX_W  active idx count
- conf_trip_cnt  out  TRIP_W  active trip count
- conf_is_new  out  1  active is_new
- conf_pad_u  out  1  pad_code[0]
- conf_pad_l  out  1  pad_code[2]
- conf_lim_r  out  LIM_W  right limit
- conf_lim_d  out  LIM_W  down limit
- conf_row_cnt  out  LIM_W  row count
- start_fc  out  1  fc job start pulse
- start_conv  out  1  conv job start pulse
- busy  out  1  job active or queued
- cfg_level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. Reset empties the FIFO and forces the FSM to IDLE. Output reset values: conf_mode=0, conf_idx_cnt=0, conf_trip_cnt=0, conf_is_new=1, conf_pad_u=0, conf_pad_l=0, conf_lim_r=0, conf_lim_d=0, conf_row_cnt=0, start_fc=0, start_conv=0, busy=0, cfg_level=0.
- Reset mid-job: discards the active job and all queued jobs; no start pulse occurs in the cycle after reset deasserts.
- Handshake:
  - cfg_ready = (cfg_level != DEPTH), combinational from occupancy only; no bypass from a same-cycle pop.
  - A push occurs on a clock edge with cfg_valid && cfg_ready && !rst.
  - The FIFO stores raw inputs, including cut_y.
  - Simultaneous push and pop leaves cfg_level unchanged.
- FSM states: IDLE, ISSUE, RUN.
  - IDLE: if FIFO is non-empty, pop the head, register all conf_* outputs, go to ISSUE. Otherwise stay.
  - ISSUE: exactly one cycle. start_fc=1 if conf_mode[0]=1, else start_conv=1. Go to RUN.
  - RUN: hold conf_* stable. On agu_done, go to IDLE.
  - agu_done outside RUN is ignored.
  - agu_done arriving in the ISSUE cycle is ignored.
- Latency:
  - Push at edge t into an empty FIFO with the FSM in IDLE: conf_* valid and start pulse high in cycle t+2.
  - agu_done at edge d with FIFO non-empty: next start pulse in cycle d+2.
- Derived fields (registered at pop; all arithmetic modulo 2^LIM_W, no saturation), with pu=pad_code[0], pd=pad_code[1]:
  - conf_row_cnt = (trip_cnt>>1) + trip_cnt[0] - 1; trip_cnt=0 wraps to all-ones.
  - conf_lim_d = KSIZE - pu - pd - cut_y.
  - conf_lim_r = trip_cnt + KSIZE - 2 - pu - pd. trip_cnt is truncated to LIM_W first.
  - pad_code[3] is stored but has no derived effect.
- busy = (state != IDLE) || (cfg_level != 0).

Test Plan:
- Single conv job: mode=00, trip_cnt=7, pad_code=0000, cut_y=0, KSIZE=3, pushed at t → in cycle t+2: start_conv=1 for one cycle, conf_row_cnt=3, conf_lim_d=3, conf_lim_r=8, conf_is_new as pushed; start_fc=0 throughout.
- FC job with padding: mode=11, trip_cnt=4, pad_code=0111, cut_y=1 → start_fc pulse; conf_row_cnt=1, conf_lim_d=0, conf_lim_r=3, conf_pad_u=1, conf_pad_l=1.
- Back-pressure: push 3 jobs with DEPTH=2 while the first runs and agu_done is held low → first job in RUN, two queued, cfg_level=2, cfg_ready=0; third accepted only in the cycle after agu_done triggers the next pop; conf_* unchanged until that pop.
- Back-to-back dispatch: 2 queued jobs, agu_done at edge d → second start pulse in cycle d+2; agu_done pulsed while in IDLE → no effect.
- Wrap case: trip_cnt=0, pad_code=0011, cut_y=1 → conf_row_cnt=63, conf_lim_r=63, conf_lim_d=0 (LIM_W=6).
- Reset mid-RUN with 1 job queued → cfg_level=0, busy=0, conf_is_new=1, no start pulse in the 3 cycles after reset deasserts.
